// File: rtl/id_ex_forward_register.sv
// ID/EX pipeline register with operand forwarding muxes, bubble insertion, branch flush
// and a saturating bubble counter for performance debug.
module id_ex_forward_register #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         fwdA,
  input  logic [1:0]         fwdB,
  input  logic               controlMux,
  input  logic               flush,
  input  logic [DATA_W-1:0]  rfA,
  input  logic [DATA_W-1:0]  rfB,
  input  logic [DATA_W-1:0]  exResult,
  input  logic [DATA_W-1:0]  memResult,
  input  logic [DATA_W-1:0]  wbResult,
  input  logic [DATA_W-1:0]  immID,
  input  logic [4:0]         regID,
  input  logic [ALUOP_W-1:0] aluOpID,
  input  logic               rfEnableID,
  input  logic               loadID,
  input  logic               memWriteID,
  output logic [DATA_W-1:0]  opA_EX,
  output logic [DATA_W-1:0]  opB_EX,
  output logic [DATA_W-1:0]  imm_EX,
  output logic [ALUOP_W-1:0] aluOpEX,
  output logic               enableEX,
  output logic               loadEX,
  output logic               memWriteEX,
  output logic [4:0]         regEX,
  output logic [CNT_W-1:0]   bubbleCount
);

  logic [DATA_W-1:0]  sel_a, sel_b;
  logic [DATA_W-1:0]  op_a_q, op_b_q, imm_q;
  logic [ALUOP_W-1:0] alu_op_q;
  logic               enable_q, load_q, mem_write_q;
  logic [4:0]         reg_q;
  logic [CNT_W-1:0]   bubble_cnt_q;

  // Case muxes keep unselected X sources from reaching the register.
  always_comb begin
    sel_a = rfA;
    unique case (fwdA)
      2'b00: sel_a = rfA;
      2'b01: sel_a = exResult;
      2'b10: sel_a = memResult;
      2'b11: sel_a = wbResult;
      default: sel_a = rfA;
    endcase
  end

  always_comb begin
    sel_b = rfB;
    unique case (fwdB)
      2'b00: sel_b = rfB;
      2'b01: sel_b = exResult;
      2'b10: sel_b = memResult;
      2'b11: sel_b = wbResult;
      default: sel_b = rfB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      imm_q       <= '0;
      alu_op_q    <= '0;
      enable_q    <= 1'b0;
      load_q      <= 1'b0;
      mem_write_q <= 1'b0;
      reg_q       <= '0;
    end else begin
      op_a_q <= sel_a;
      op_b_q <= sel_b;
      imm_q  <= immID;
      if (controlMux) begin
        // Bubble: operands still load, but nothing with a side effect survives.
        alu_op_q    <= '0;
        enable_q    <= 1'b0;
        load_q      <= 1'b0;
        mem_write_q <= 1'b0;
        reg_q       <= '0;
      end else begin
        alu_op_q    <= aluOpID;
        enable_q    <= rfEnableID;
        load_q      <= loadID;
        mem_write_q <= memWriteID;
        reg_q       <= regID;
      end
    end
  end

  // Flushes are not bubbles; the counter holds at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= '0;
    end else if (!flush && controlMux && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign opA_EX      = op_a_q;
  assign opB_EX      = op_b_q;
  assign imm_EX      = imm_q;
  assign aluOpEX     = alu_op_q;
  assign enableEX    = enable_q;
  assign loadEX      = load_q;
  assign memWriteEX  = mem_write_q;
  assign regEX       = reg_q;
  assign bubbleCount = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_forward_register.sv
// Directed bench for id_ex_forward_register: vector table plus reset/saturation sequences.
module tb_id_ex_forward_register;

  logic        clk = 1'b0;
  logic        reset, controlMux, flush;
  logic [1:0]  fwdA, fwdB;
  logic [31:0] rfA, rfB, exResult, memResult, wbResult, immID;
  logic [4:0]  regID;
  logic [3:0]  aluOpID;
  logic        rfEnableID, loadID, memWriteID;

  logic [31:0] opA_EX, opB_EX, imm_EX;
  logic [3:0]  aluOpEX;
  logic        enableEX, loadEX, memWriteEX;
  logic [4:0]  regEX;
  logic [15:0] bubbleCount;

  logic [31:0] s_opA_EX, s_opB_EX, s_imm_EX;
  logic [3:0]  s_aluOpEX;
  logic        s_enableEX, s_loadEX, s_memWriteEX;
  logic [4:0]  s_regEX;
  logic [3:0]  s_bubbleCount;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_forward_register dut (
    .clk(clk), .reset(reset), .fwdA(fwdA), .fwdB(fwdB), .controlMux(controlMux),
    .flush(flush), .rfA(rfA), .rfB(rfB), .exResult(exResult), .memResult(memResult),
    .wbResult(wbResult), .immID(immID), .regID(regID), .aluOpID(aluOpID),
    .rfEnableID(rfEnableID), .loadID(loadID), .memWriteID(memWriteID),
    .opA_EX(opA_EX), .opB_EX(opB_EX), .imm_EX(imm_EX), .aluOpEX(aluOpEX),
    .enableEX(enableEX), .loadEX(loadEX), .memWriteEX(memWriteEX), .regEX(regEX),
    .bubbleCount(bubbleCount)
  );

  id_ex_forward_register #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .fwdA(fwdA), .fwdB(fwdB), .controlMux(controlMux),
    .flush(flush), .rfA(rfA), .rfB(rfB), .exResult(exResult), .memResult(memResult),
    .wbResult(wbResult), .immID(immID), .regID(regID), .aluOpID(aluOpID),
    .rfEnableID(rfEnableID), .loadID(loadID), .memWriteID(memWriteID),
    .opA_EX(s_opA_EX), .opB_EX(s_opB_EX), .imm_EX(s_imm_EX), .aluOpEX(s_aluOpEX),
    .enableEX(s_enableEX), .loadEX(s_loadEX), .memWriteEX(s_memWriteEX), .regEX(s_regEX),
    .bubbleCount(s_bubbleCount)
  );

  typedef struct {
    logic [1:0]  fa, fb;
    logic        cm, fl;
    logic [31:0] ra, rb, ex, mem, wb, imm;
    logic [4:0]  rg;
    logic [3:0]  alu;
    logic        en, ld, mw;
    logic [31:0] e_opa, e_opb, e_imm;
    logic [3:0]  e_alu;
    logic        e_en, e_ld, e_mw;
    logic [4:0]  e_reg;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input logic [31:0] v);
    fwdA = v[1:0]; fwdB = v[3:2];
    rfA = v; rfB = v; exResult = v; memResult = v; wbResult = v; immID = v;
    regID = v[4:0]; aluOpID = v[3:0];
    rfEnableID = 1'b1; loadID = 1'b1; memWriteID = 1'b1;
  endtask

  task automatic check_all_zero(input string tag, input logic [15:0] cnt);
    check({tag, ".opA"}, 64'(opA_EX), 64'h0);
    check({tag, ".opB"}, 64'(opB_EX), 64'h0);
    check({tag, ".imm"}, 64'(imm_EX), 64'h0);
    check({tag, ".alu"}, 64'(aluOpEX), 64'h0);
    check({tag, ".ctl"}, 64'({enableEX, loadEX, memWriteEX}), 64'h0);
    check({tag, ".reg"}, 64'(regEX), 64'h0);
    check({tag, ".cnt"}, 64'(bubbleCount), 64'(cnt));
  endtask

  initial begin
    //        fa fb cm fl ra            rb            ex            mem           wb            imm            rg     alu   en ld mw | opa           opb           imm            alu   en ld mw reg    cnt
    vecs[0] = '{0, 3, 0, 0, 32'h11,       32'hAB,       32'h22,       32'h33,       32'h44,       32'h100,       5'd3,  4'h2, 1, 0, 1, 32'h11,       32'h44,       32'h100,       4'h2, 1, 0, 1, 5'd3,  16'd0};
    vecs[1] = '{1, 3, 0, 0, 32'h11,       32'hAB,       32'h22,       32'h33,       32'h44,       32'h100,       5'd3,  4'h2, 1, 0, 1, 32'h22,       32'h44,       32'h100,       4'h2, 1, 0, 1, 5'd3,  16'd0};
    vecs[2] = '{2, 3, 0, 0, 32'h11,       32'hAB,       32'h22,       32'h33,       32'h44,       32'h100,       5'd3,  4'h2, 1, 0, 1, 32'h33,       32'h44,       32'h100,       4'h2, 1, 0, 1, 5'd3,  16'd0};
    vecs[3] = '{3, 3, 0, 0, 32'h11,       32'hAB,       32'h22,       32'h33,       32'h44,       32'h100,       5'd3,  4'h2, 1, 0, 1, 32'h44,       32'h44,       32'h100,       4'h2, 1, 0, 1, 5'd3,  16'd0};
    vecs[4] = '{0, 0, 1, 0, 32'h11,       32'hAB,       32'h22,       32'h33,       32'h44,       32'h55,        5'd7,  4'h5, 1, 1, 1, 32'h11,       32'hAB,       32'h55,        4'h0, 0, 0, 0, 5'd0,  16'd1};
    vecs[5] = '{1, 1, 1, 1, 32'h11,       32'hAB,       32'h22,       32'h33,       32'h44,       32'h55,        5'd7,  4'h5, 1, 1, 1, 32'h0,        32'h0,        32'h0,         4'h0, 0, 0, 0, 5'd0,  16'd1};
    vecs[6] = '{1, 1, 0, 0, 32'h11,       32'hAB,       32'h22,       32'h33,       32'h44,       32'h7,         5'd0,  4'h9, 1, 0, 0, 32'h22,       32'h22,       32'h7,         4'h9, 1, 0, 0, 5'd0,  16'd1};
    vecs[7] = '{0, 2, 0, 0, 32'hDEADBEEF, 32'hAB,       32'hx,        32'h33,       32'hx,        32'hFFFFFFFF,  5'd31, 4'hF, 0, 1, 0, 32'hDEADBEEF, 32'h33,       32'hFFFFFFFF,  4'hF, 0, 1, 0, 5'd31, 16'd1};
    vecs[8] = '{2, 3, 1, 0, 32'hx,        32'hx,        32'hx,        32'h1234,     32'h5678,     32'h9,         5'd4,  4'h3, 1, 1, 1, 32'h1234,     32'h5678,     32'h9,         4'h0, 0, 0, 0, 5'd0,  16'd2};
    vecs[9] = '{0, 0, 1, 0, 32'hA,        32'hB,        32'hC,        32'hD,        32'hE,        32'hF,         5'd8,  4'h1, 1, 0, 1, 32'hA,        32'hB,        32'hF,         4'h0, 0, 0, 0, 5'd0,  16'd3};

    // Reset with every input non-zero and the bubble/flush controls active.
    reset = 1'b1; flush = 1'b1; controlMux = 1'b1;
    drive_all(32'hFFFF_FFFF);
    step();
    check_all_zero("reset", 16'd0);
    check("reset.small_cnt", 64'(s_bubbleCount), 64'h0);

    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      fwdA = vecs[i].fa; fwdB = vecs[i].fb; controlMux = vecs[i].cm; flush = vecs[i].fl;
      rfA = vecs[i].ra; rfB = vecs[i].rb; exResult = vecs[i].ex;
      memResult = vecs[i].mem; wbResult = vecs[i].wb; immID = vecs[i].imm;
      regID = vecs[i].rg; aluOpID = vecs[i].alu;
      rfEnableID = vecs[i].en; loadID = vecs[i].ld; memWriteID = vecs[i].mw;
      step();
      check($sformatf("v%0d.opA", i), 64'(opA_EX), 64'(vecs[i].e_opa));
      check($sformatf("v%0d.opB", i), 64'(opB_EX), 64'(vecs[i].e_opb));
      check($sformatf("v%0d.imm", i), 64'(imm_EX), 64'(vecs[i].e_imm));
      check($sformatf("v%0d.alu", i), 64'(aluOpEX), 64'(vecs[i].e_alu));
      check($sformatf("v%0d.en", i), 64'(enableEX), 64'(vecs[i].e_en));
      check($sformatf("v%0d.ld", i), 64'(loadEX), 64'(vecs[i].e_ld));
      check($sformatf("v%0d.mw", i), 64'(memWriteEX), 64'(vecs[i].e_mw));
      check($sformatf("v%0d.reg", i), 64'(regEX), 64'(vecs[i].e_reg));
      check($sformatf("v%0d.cnt", i), 64'(bubbleCount), 64'(vecs[i].e_cnt));
    end

    // Mid-run reset beats a simultaneous bubble request; bubbleCount was 3.
    reset = 1'b1; controlMux = 1'b1; flush = 1'b0;
    drive_all(32'h1357_9BDF);
    step();
    check_all_zero("midreset", 16'd0);

    reset = 1'b0; controlMux = 1'b0;
    regID = 5'd9; aluOpID = 4'h6; immID = 32'h42; fwdA = 2'b00; fwdB = 2'b01;
    rfA = 32'hA5; exResult = 32'h5A; rfEnableID = 1'b1; loadID = 1'b0; memWriteID = 1'b0;
    step();
    check("postreset.reg", 64'(regEX), 64'd9);
    check("postreset.alu", 64'(aluOpEX), 64'h6);
    check("postreset.opA", 64'(opA_EX), 64'hA5);
    check("postreset.opB", 64'(opB_EX), 64'h5A);
    check("postreset.en", 64'(enableEX), 64'h1);
    check("postreset.cnt", 64'(bubbleCount), 64'h0);
    check("postreset.small_cnt", 64'(s_bubbleCount), 64'h0);

    // 20 bubbles: 4-bit counter saturates at 15, 16-bit counter keeps counting.
    controlMux = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("sat%0d.small_cnt", i), 64'(s_bubbleCount), 64'((i + 1 > 15) ? 15 : i + 1));
      check($sformatf("sat%0d.cnt", i), 64'(bubbleCount), 64'(i + 1));
    end
    check("sat.small_reg", 64'(s_regEX), 64'h0);

    // Flush during saturation leaves the counter alone.
    flush = 1'b1;
    step();
    check("satflush.small_cnt", 64'(s_bubbleCount), 64'd15);
    check_all_zero("satflush", 16'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_forward_register.md
Name: id_ex_forward_register

Overview:
- ID/EX pipeline register sitting directly downstream of the hazard/forwarding unit.
- Consumes fwdA/fwdB to select each source operand from one of four places: the register file, the EX result, the MEM result or the WB result. Registers the selected operands, immediate, destination register and control bundle into EX.
- Inserts a NOP bubble when controlMux=1 and clears itself on a branch flush.
- Feeds enableEX/loadEX/regEX back to the hazard unit and keeps a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 32, operand/result datapath width
- ALUOP_W, 4, ALU operation code width
- CNT_W, 16, bubble counter width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- fwdA  input  2  operand A source select: 00 RF, 01 EX, 10 MEM, 11 WB
- fwdB  input  2  operand B source select, same encoding
- controlMux  input  1  1 = load NOP bubble into ID/EX
- flush  input  1  1 = clear ID/EX (taken branch/jump)
- rfA  input  DATA_W  register-file read port A
- rfB  input  DATA_W  register-file read port B
- exResult  input  DATA_W  EX-stage ALU result
- memResult  input  DATA_W  MEM-stage result
- wbResult  input  DATA_W  WB-stage write data
- immID  input  DATA_W  sign/zero-extended immediate from ID
- regID  input  5  destination register from ID
- aluOpID  input  ALUOP_W  ALU op from control unit
- rfEnableID  input  1  RF write enable from control unit
- loadID  input  1  load instruction flag
- memWriteID  input  1  store instruction flag
- opA_EX  output  DATA_W  registered operand A
- opB_EX  output  DATA_W  registered operand B
- imm_EX  output  DATA_W  registered immediate
- aluOpEX  output  ALUOP_W  registered ALU op
- enableEX  output  1  registered RF write enable (to hazard unit)
- loadEX  output  1  registered load flag (to hazard unit)
- memWriteEX  output  1  registered store flag
- regEX  output  5  registered destination register (to hazard unit)
- bubbleCount  output  CNT_W  bubbles inserted since reset

Behaviour:
- Reset values: every output register is 0, including bubbleCount.
- Operand select is combinational before the register:
  - selA = fwdA 00:rfA, 01:exResult, 10:memResult, 11:wbResult.
  - selB is built the same way from fwdB.
- Latency is 1 cycle: ID values presented in cycle N appear on the *_EX outputs after clock edge N.
- Per-edge priority, highest first: reset > flush > controlMux > normal load. There is no hold state: ID/EX updates on every non-reset edge.
- reset=1: all outputs are cleared to 0.
- flush=1 (reset=0): all outputs except bubbleCount are cleared to 0. bubbleCount is unchanged, and the flush does not count as a bubble.
- controlMux=1 (reset=0, flush=0):
  - enableEX, loadEX, memWriteEX, aluOpEX and regEX load 0.
  - opA_EX/opB_EX/imm_EX load selA/selB/immID as normal.
  - bubbleCount increments by 1, saturating at all-ones; it never wraps.
- Normal load: every output loads its selected or ID input.
- regEX=0 with enableEX=1 is legal and passed through unchanged. This block does not suppress $zero writes.
- An X on unused forward sources must not propagate: only the selected input reaches the register.
- Reset asserted mid-stream overrides flush and controlMux in the same cycle. The cycle after reset deasserts behaves as a normal load.

Test Plan:
- Reset: assert reset with all inputs non-zero -> after the edge every output is 0 and bubbleCount=0.
- Forward select:
  - Inputs: rfA=0x11, exResult=0x22, memResult=0x33, wbResult=0x44.
  - Sweep fwdA 00..11 with fwdB fixed at 11.
  - Required: opA_EX = 0x11, 0x22, 0x33, 0x44 on successive cycles, and opB_EX stays 0x44 throughout.
- Bubble:
  - Inputs: regID=7, enableID=1, loadID=1, aluOpID=5, controlMux=1, rfB=0xAB, fwdB=00.
  - Required: regEX=0, enableEX=0, loadEX=0, aluOpEX=0, opB_EX=0xAB, bubbleCount=1.
- Flush priority: flush=1 and controlMux=1 in the same cycle -> all pipeline outputs 0 and bubbleCount unchanged.
- Saturation: with CNT_W=4, hold controlMux=1 for 20 cycles -> bubbleCount reaches 15 and stays at 15.
- Mid-run reset: after bubbleCount reaches 3, assert reset together with controlMux=1 -> bubbleCount=0 and all outputs 0. The next normal cycle loads regID=9 -> regEX=9.
